// File: rtl/crc16_pkg.sv
`default_nettype none
// ============================================================================
// Module  : crc16_pkg
// Brief   : Shared constants and FSM state type for the CRC-16 generator.
// Revision: 1.0
// ============================================================================
package crc16_pkg;

    localparam logic [15:0] POLY   = 16'h100B;
    localparam logic [15:0] INIT   = 16'hFFFF;
    localparam int          DATA_W = 96;
    localparam int          OUT_W  = 128;
    localparam int          CRC_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/crc16_step.sv
`default_nettype none
// ============================================================================
// Module  : crc16_step
// Brief   : Combinational fold of an NUMB-bit chunk (MSB first) into the CRC.
// Revision: 1.0
// ============================================================================
module crc16_step
    import crc16_pkg::*;
#(
    parameter int NUMB = 16
) (
    input  logic [NUMB-1:0]  i_chunk,
    input  logic [CRC_W-1:0] i_crc,
    output logic [CRC_W-1:0] o_crc
);

    logic [CRC_W-1:0] w_acc;

    // Unrolled serial LFSR: one shift per chunk bit, most significant bit first.
    always_comb begin
        w_acc = i_crc;
        for (int i = NUMB - 1; i >= 0; i--) begin
            w_acc = {w_acc[CRC_W-2:0], 1'b0} ^ ((w_acc[CRC_W-1] ^ i_chunk[i]) ? POLY : '0);
        end
        o_crc = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/crc16_gen.sv
`default_nettype none
// ============================================================================
// Module  : crc16_gen
// Brief   : Multi-cycle CRC-16 (0x100B) over a captured 96-bit word, NUMB bits
//           per clock. Define CRC_OUT_INVERT_EN to output the ones-complement.
// Revision: 1.0
// ============================================================================
module crc16_gen
    import crc16_pkg::*;
#(
    parameter int NUMB = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  q,
    output logic [OUT_W-1:0]  dataOut,
    output logic              rdy
);

    localparam int c_STEPS = DATA_W / NUMB;
    localparam int c_CNT_W = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;

    state_t             r_state;
    logic [DATA_W-1:0]  d;
    logic [DATA_W-1:0]  r_held;
    logic [CRC_W-1:0]   r_crc;
    logic [c_CNT_W-1:0] r_cnt;

    logic [NUMB-1:0]    w_chunk;
    logic [CRC_W-1:0]   w_crc_next;
    logic [CRC_W-1:0]   w_crc_out;

    assign w_chunk = d[DATA_W-1 -: NUMB];

    crc16_step #(
        .NUMB (NUMB)
    ) u_step (
        .i_chunk (w_chunk),
        .i_crc   (r_crc),
        .o_crc   (w_crc_next)
    );

`ifdef CRC_OUT_INVERT_EN
    assign w_crc_out = ~w_crc_next;
`else
    assign w_crc_out = w_crc_next;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            d       <= '0;
            r_held  <= '0;
            r_crc   <= INIT;
            r_cnt   <= '0;
            q       <= '0;
            dataOut <= '0;
            rdy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!we) begin
                        d       <= data;
                        r_held  <= data;
                        r_crc   <= INIT;
                        r_cnt   <= c_CNT_W'(c_STEPS - 1);
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_crc <= w_crc_next;
                    d     <= d << NUMB;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == '0) begin
                        q       <= w_crc_out;
                        dataOut <= {r_held, w_crc_out, 16'h0000};
                        rdy     <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Result held until the strobe is released; no auto-restart.
                    if (we) begin
                        rdy     <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc16_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_crc16_gen
// Brief   : Scoreboard bench for crc16_gen against a bitwise CRC model.
// Revision: 1.0
// ============================================================================
module tb_crc16_gen;

    parameter int NUMB = 16;
    localparam int LAT = 96 / NUMB;

    typedef struct {
        logic [15:0]  q;
        logic [127:0] dout;
        int           cap;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         we;
    logic [95:0]  data;
    logic [15:0]  q;
    logic [127:0] dataOut;
    logic         rdy;

    int   n_cmp;
    int   n_bad;
    int   cyc;
    exp_t sb[$];
    logic prev_rdy;

    crc16_gen #(.NUMB(NUMB)) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .data    (data),
        .q       (q),
        .dataOut (dataOut),
        .rdy     (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain bit-serial CRC over all 96 bits, MSB first.
    function automatic logic [15:0] model_crc(input logic [95:0] v);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 95; i >= 0; i--) begin
            fb = c[15] ^ v[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h100B;
        end
`ifdef CRC_OUT_INVERT_EN
        c = ~c;
`endif
        return c;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pop one expected result on each rising edge of rdy.
    always @(negedge clk) begin
        exp_t e;
        if (rdy && !prev_rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_rdy", 128'd1, 128'd0);
            end else begin
                e = sb.pop_front();
                check("q", {112'd0, q}, {112'd0, e.q});
                check("dataOut", dataOut, e.dout);
                check("dataOut_hi", {32'd0, dataOut[127:32]}, {32'd0, e.dout[127:32]});
                check("dataOut_lo", {112'd0, dataOut[15:0]}, 128'd0);
                check("latency", 128'(cyc - e.cap), 128'(LAT));
            end
        end
        prev_rdy <= rdy;
    end

    task automatic start_job(input logic [95:0] v, input bit hold, output exp_t e);
        logic [15:0] m;
        @(negedge clk);
        we   = 1'b0;
        data = v;
        @(posedge clk);
        #1;
        m     = model_crc(v);
        e.q   = m;
        e.dout = {v, m, 16'h0000};
        e.cap = cyc;
        sb.push_back(e);
        if (!hold) we = 1'b1;
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (!rdy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) check("rdy_timeout", 128'd0, 128'd1);
    endtask

    task automatic run_job(input logic [95:0] v);
        exp_t e;
        start_job(v, 1'b0, e);
        wait_rdy();
        @(negedge clk);
        check("rdy_release", {127'd0, rdy}, 128'd0);
    endtask

    initial begin
        exp_t e;
        logic [95:0] v;
        n_cmp    = 0;
        n_bad    = 0;
        cyc      = 0;
        prev_rdy = 1'b0;
        rst      = 1'b0;
        we       = 1'b1;
        data     = '0;

        #3;
        check("rst_q", {112'd0, q}, 128'd0);
        check("rst_dataOut", dataOut, 128'd0);
        check("rst_rdy", {127'd0, rdy}, 128'd0);
        check("rst_d", {32'd0, dut.d}, 128'd0);
        #7 rst = 1'b1;

        // Known vector, then an all-zero word.
        run_job(96'h111122223333444455556666);
        run_job(96'h0);

        // Data changes mid-CALC must not affect the result.
        start_job(96'h111122223333444455556666, 1'b0, e);
        @(negedge clk);
        data = 96'h11112222000044445555AAAA;
        wait_rdy();
        @(negedge clk);

        // Async reset during CALC discards the job.
        start_job({$urandom, $urandom, $urandom}, 1'b0, e);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        void'(sb.pop_back());
        check("midrst_q", {112'd0, q}, 128'd0);
        check("midrst_dataOut", dataOut, 128'd0);
        check("midrst_rdy", {127'd0, rdy}, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        run_job(96'hDEADBEEF_CAFEF00D_01234567);

        // Strobe held low: result stays until release, then next job.
        start_job({$urandom, $urandom, $urandom}, 1'b1, e);
        wait_rdy();
        repeat (3) @(negedge clk);
        check("hold_rdy", {127'd0, rdy}, 128'd1);
        check("hold_q", {112'd0, q}, {112'd0, e.q});
        we = 1'b1;
        @(negedge clk);
        check("drop_rdy", {127'd0, rdy}, 128'd0);
        check("drop_q", {112'd0, q}, {112'd0, e.q});
        check("drop_dataOut", dataOut, e.dout);

        for (int k = 0; k < 12; k++) begin
            v = {$urandom, $urandom, $urandom};
            run_job(v);
        end
        run_job({96{1'b1}});

        repeat (4) @(negedge clk);
        check("sb_empty", 128'(sb.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
